eth_tx_pkt_fifo: RTL and testbench

ETH_TX_PKT_FIFO -- requirements
Module: eth_tx_pkt_fifo

---
 rtl/eth_pkg.sv | 32 +++
 rtl/eth_tx_ram.sv | 29 ++
 rtl/eth_tx_pkt_fifo.sv | 176 +++++++++++++++++
 tb/tb_eth_tx_pkt_fifo.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX constants, FIFO word layout and write-FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eth_pkg;

  localparam int DATA_W = 32;
  localparam int WORD_W = DATA_W + 2;

  typedef enum logic [1:0] {
    PKT_NONE = 2'd0,
    ARP_REQ  = 2'd1,
    ARP_RESP = 2'd2,
    UDP      = 2'd3
  } pkt_type_e;

  localparam logic [15:0] ETYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } wr_state_e;

  // One stored beat: frame markers travel alongside the data word.
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } word_t;

endpackage

// File: rtl/eth_tx_ram.sv
// Simple dual-port frame buffer RAM, one write port and one registered read port.
// Latency: read data valid one cycle after rd_en.
// Backpressure: none; rd_data holds its value while rd_en is low.
module eth_tx_ram #(
  parameter int ADDR_W = 10,
  parameter int WIDTH  = 34
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; holds while not enabled so a stalled output stays stable.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_tx_pkt_fifo.sv
// Store-and-forward TX packet FIFO feeding an Avalon-ST MAC; frames leave only once fully committed.
// Latency: eop accepted in cycle N into an empty buffer -> first output beat valid in cycle N+2.
// Backpressure: o_rdy drops when the buffer is full or MAX_PKTS frames are held; output stalls hold o_* stable.
module eth_tx_pkt_fifo
  import eth_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int MAX_PKTS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_vld,
  input  logic              i_sop,
  input  logic              i_eop,
  output logic              o_rdy,
  output logic [DATA_W-1:0] o_data,
  output logic              o_vld,
  output logic              o_sop,
  output logic              o_eop,
  output logic [1:0]        o_empty,
  input  logic              i_rdy,
  output logic [4:0]        o_pkt_cnt,
  output logic              o_drop,
  output logic              o_err
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [4:0]      MAX_CNT = 5'(MAX_PKTS);

  wr_state_e       state, state_nxt;
  logic [ADDR_W:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W:0] commit_ptr, commit_nxt;
  logic [ADDR_W:0] start_ptr, start_nxt;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] base_ptr;
  logic [4:0]      pkt_cnt;

  logic            full, accept, commit, err_nxt, drop_nxt;
  logic            ram_we, rd_en, out_eop_xfer;
  logic [ADDR_W-1:0] ram_waddr;
  word_t           ram_wdat, ram_q;

  assign full   = (wr_ptr - rd_ptr) == DEPTH;
  // Held low during reset; DROP always sinks beats so an oversized frame can finish.
  assign o_rdy  = rst_n && ((state == DROP) || (!full && (pkt_cnt < MAX_CNT)));
  assign accept = i_vld && o_rdy;

  // A sop arriving mid-frame restarts the frame over the abandoned partial one.
  assign base_ptr = (state == FILL && i_sop) ? start_ptr : wr_ptr;

  // Write FSM next-state, RAM write and commit decisions.
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    commit_nxt = commit_ptr;
    start_nxt  = start_ptr;
    ram_we     = 1'b0;
    ram_waddr  = base_ptr[ADDR_W-1:0];
    ram_wdat   = '{sop: i_sop, eop: i_eop, data: i_data};
    commit     = 1'b0;
    err_nxt    = 1'b0;
    drop_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!i_sop) begin
            err_nxt = 1'b1;
          end else begin
            ram_we     = 1'b1;
            start_nxt  = wr_ptr;
            wr_ptr_nxt = wr_ptr + 1'b1;
            if (i_eop) begin
              commit     = 1'b1;
              commit_nxt = wr_ptr + 1'b1;
            end else begin
              state_nxt = FILL;
            end
          end
        end
      end
      FILL: begin
        if (accept) begin
          ram_we     = 1'b1;
          wr_ptr_nxt = base_ptr + 1'b1;
          err_nxt    = i_sop;
          if (i_eop) begin
            commit     = 1'b1;
            commit_nxt = base_ptr + 1'b1;
            state_nxt  = IDLE;
          end
        end else if (full && pkt_cnt == '0) begin
          // Nothing left to drain, so this frame alone exceeds the buffer.
          wr_ptr_nxt = start_ptr;
          state_nxt  = DROP;
        end
      end
      DROP: begin
        if (accept && i_eop) begin
          drop_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write-side state, pointers and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      start_ptr  <= '0;
      o_err      <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_nxt;
      start_ptr  <= start_nxt;
      o_err      <= err_nxt;
      o_drop     <= drop_nxt;
    end
  end

  // Prefetch whenever the output register is free or draining and committed words remain.
  assign rd_en        = (!o_vld || i_rdy) && (rd_ptr != commit_ptr);
  assign out_eop_xfer = o_vld && i_rdy && ram_q.eop;

  // Read pointer and output-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      o_vld  <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (rd_en)      o_vld <= 1'b1;
      else if (i_rdy) o_vld <= 1'b0;
    end
  end

  // Committed-but-unsent frame count; commit and output eop in one cycle cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else begin
      case ({commit, out_eop_xfer})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  eth_tx_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (WORD_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdat),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

  // RAM read register has no reset, so outputs are masked until a real beat is loaded.
  assign o_data    = o_vld ? ram_q.data : '0;
  assign o_sop     = o_vld && ram_q.sop;
  assign o_eop     = o_vld && ram_q.eop;
  assign o_empty   = 2'd0;
  assign o_pkt_cnt = pkt_cnt;

endmodule

// File: tb/tb_eth_tx_pkt_fifo.sv
// Self-checking bench: frame-level scoreboard model for the default-size FIFO, directed checks for a 16-word one.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_eth_tx_pkt_fifo;
  import eth_pkg::*;

  localparam int DEPTH_A = 1024;
  localparam int MAXP    = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] i_data = '0;
  logic i_sop = 1'b0, i_eop = 1'b0, vld_a = 1'b0, vld_b = 1'b0;
  logic rdy_a = 1'b1, rdy_b = 1'b1;

  logic o_rdy_a, o_vld_a, o_sop_a, o_eop_a, o_drop_a, o_err_a;
  logic [31:0] o_data_a; logic [1:0] o_empty_a; logic [4:0] o_pkt_cnt_a;
  logic o_rdy_b, o_vld_b, o_sop_b, o_eop_b, o_drop_b, o_err_b;
  logic [31:0] o_data_b; logic [1:0] o_empty_b; logic [4:0] o_pkt_cnt_b;

  always #5 clk = ~clk;

  eth_tx_pkt_fifo #(.ADDR_W(10), .MAX_PKTS(MAXP)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_vld(vld_a), .i_sop(i_sop), .i_eop(i_eop),
    .o_rdy(o_rdy_a), .o_data(o_data_a), .o_vld(o_vld_a), .o_sop(o_sop_a), .o_eop(o_eop_a),
    .o_empty(o_empty_a), .i_rdy(rdy_a), .o_pkt_cnt(o_pkt_cnt_a), .o_drop(o_drop_a), .o_err(o_err_a));

  eth_tx_pkt_fifo #(.ADDR_W(4), .MAX_PKTS(MAXP)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_vld(vld_b), .i_sop(i_sop), .i_eop(i_eop),
    .o_rdy(o_rdy_b), .o_data(o_data_b), .o_vld(o_vld_b), .o_sop(o_sop_b), .o_eop(o_eop_b),
    .o_empty(o_empty_b), .i_rdy(rdy_b), .o_pkt_cnt(o_pkt_cnt_b), .o_drop(o_drop_b), .o_err(o_err_b));

  int nvec = 0, nmis = 0;
  int cyc = 0, last_acc = 0, first_vld = -1, last_xfer = 0;
  int a_beats = 0, a_errs = 0, a_drops = 0;
  int b_beats = 0, b_errs = 0, b_drops = 0;
  logic [31:0] b_out[$];
  logic [31:0] sent_q[$];

  int   rdy_mode = 0;
  logic rdy_val  = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // MAC ready pattern for DUT A: fixed, toggling, or random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       rdy_a = ~rdy_a;
      2:       rdy_a = ($urandom_range(0, 2) != 0);
      default: rdy_a = rdy_val;
    endcase
  end

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model of DUT A ----------------
  typedef enum {M_IDLE, M_FILL, M_DROP} mst_e;
  mst_e        m_st = M_IDLE;
  logic [33:0] exp_q[$];
  logic [33:0] cur[$];
  int          m_cnt = 0, cnt_pre = 0;
  logic        m_err = 1'b0, m_drop = 1'b0, prev_stall = 1'b0, acc;
  logic [33:0] beat;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_vld", o_vld_a, 0);   chk("rst_sop", o_sop_a, 0);  chk("rst_eop", o_eop_a, 0);
      chk("rst_data", o_data_a, 0); chk("rst_cnt", o_pkt_cnt_a, 0);
      chk("rst_err", o_err_a, 0);   chk("rst_drop", o_drop_a, 0); chk("rst_rdy", o_rdy_a, 0);
      exp_q.delete(); cur.delete();
      m_st = M_IDLE; m_cnt = 0; m_err = 1'b0; m_drop = 1'b0; prev_stall = 1'b0;
    end else begin
      cnt_pre = m_cnt;
      chk("pkt_cnt", o_pkt_cnt_a, 34'(m_cnt));
      chk("err", o_err_a, m_err);
      chk("drop", o_drop_a, m_drop);
      chk("empty", o_empty_a, 0);
      if (o_err_a) a_errs++;
      if (o_drop_a) a_drops++;
      if (m_st == M_DROP)                          chk("rdy_drop", o_rdy_a, 1);
      else if (m_cnt >= MAXP)                      chk("rdy_cntmax", o_rdy_a, 0);
      else if (cur.size() + exp_q.size() < DEPTH_A) chk("rdy_space", o_rdy_a, 1);
      if (prev_stall) chk("vld_hold", o_vld_a, 1);
      if (o_vld_a) begin
        if (first_vld < 0) first_vld = cyc;
        if (exp_q.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL stale_beat: got data %0h with no committed beat pending (t=%0t)", o_data_a, $time);
        end else begin
          chk("beat", {o_sop_a, o_eop_a, o_data_a}, exp_q[0]);
        end
        if (rdy_a) begin
          a_beats++; last_xfer = cyc;
          if (exp_q.size() != 0) begin
            if (exp_q[0][32]) m_cnt--;
            void'(exp_q.pop_front());
          end
        end
      end
      // Predict what the coming edge does with the beat presented now.
      m_err = 1'b0; m_drop = 1'b0;
      acc  = vld_a && o_rdy_a;
      beat = {i_sop, i_eop, i_data};
      case (m_st)
        M_IDLE: if (acc) begin
          if (!i_sop) m_err = 1'b1;
          else begin
            cur.delete(); cur.push_back(beat);
            if (i_eop) begin foreach (cur[k]) exp_q.push_back(cur[k]); cur.delete(); m_cnt++; end
            else m_st = M_FILL;
          end
        end
        M_FILL: if (acc) begin
          if (i_sop) begin m_err = 1'b1; cur.delete(); end
          cur.push_back(beat);
          if (i_eop) begin
            foreach (cur[k]) exp_q.push_back(cur[k]);
            cur.delete(); m_cnt++; m_st = M_IDLE;
          end
        end else if (cur.size() == DEPTH_A && cnt_pre == 0) begin
          cur.delete(); m_st = M_DROP;
        end
        default: if (acc && i_eop) begin m_drop = 1'b1; m_st = M_IDLE; end
      endcase
      prev_stall = o_vld_a && !rdy_a;
    end
  end

  // DUT B observation for the directed small-buffer checks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_vld_b && rdy_b) begin b_out.push_back(o_data_b); b_beats++; end
      if (o_drop_b) b_drops++;
      if (o_err_b) b_errs++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send_beat(input bit sel, input logic [31:0] d, input logic s, input logic e, input int gap);
    bit ok; int n;
    repeat (gap) begin @(posedge clk); #1; end
    i_data = d; i_sop = s; i_eop = e;
    if (sel) vld_b = 1'b1; else vld_a = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 4000) begin
      @(negedge clk); ok = sel ? o_rdy_b : o_rdy_a;
      @(posedge clk); #1; n++;
    end
    vld_a = 1'b0; vld_b = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    last_acc = cyc - 1;
    if (!ok) begin
      nvec++; nmis++;
      $display("FAIL accept_timeout: beat %0h not accepted after %0d cycles", d, n);
    end
  endtask

  task automatic send_frame(input bit sel, input int len, input int maxgap, input logic [15:0] et);
    logic [31:0] d;
    sent_q.delete();
    for (int k = 0; k < len; k++) begin
      d = (k == 3) ? {et, 16'h0001} : $urandom;
      sent_q.push_back(d);
      send_beat(sel, d, k == 0, k == len - 1, $urandom_range(0, maxgap));
    end
  endtask

  task automatic wait_drain_a();
    int n = 0;
    while ((exp_q.size() != 0 || o_vld_a) && n < 20000) begin @(posedge clk); #1; n++; end
    if (n >= 20000) begin
      nvec++; nmis++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  int b0, e0, d0, bb0, bd0, be0;
  logic [31:0] b_sent[$];

  initial begin
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("lit_rst_rdy", o_rdy_a, 0);
    chk("lit_rst_vld", o_vld_a, 0);
    rst_n = 1'b1; #1;
    chk("lit_rdy_after_rst", o_rdy_a, 1);
    @(posedge clk); #1;

    // 11-word ARP frame, MAC always ready.
    first_vld = -1; b0 = a_beats;
    send_frame(0, 11, 0, ETYPE_ARP);
    chk("lit_arp_cnt_commit", o_pkt_cnt_a, 1);
    wait_drain_a();
    chk("lit_arp_latency", 34'(first_vld - last_acc), 2);
    chk("lit_arp_b2b", 34'(last_xfer - first_vld), 10);
    chk("lit_arp_beats", 34'(a_beats - b0), 11);
    chk("lit_arp_cnt_done", o_pkt_cnt_a, 0);

    // 361-word UDP frame with ready toggling every cycle.
    b0 = a_beats; e0 = a_errs; d0 = a_drops;
    rdy_mode = 1;
    send_frame(0, 361, 0, ETYPE_IPV4);
    wait_drain_a();
    rdy_mode = 0; rdy_val = 1'b1;
    chk("lit_udp_beats", 34'(a_beats - b0), 361);
    chk("lit_udp_noerr", 34'((a_errs - e0) + (a_drops - d0)), 0);

    // 16 frames parked with MAC stalled, the 17th must wait.
    b0 = a_beats; rdy_val = 1'b0;
    @(posedge clk); #1;
    for (int f = 0; f < 16; f++) send_frame(0, 11, 0, ETYPE_ARP);
    chk("lit_cnt16", o_pkt_cnt_a, 16);
    chk("lit_rdy_cnt16", o_rdy_a, 0);
    fork
      send_frame(0, 11, 0, ETYPE_ARP);
      begin
        repeat (20) begin @(posedge clk); #1; end
        chk("lit_rdy_17th_blocked", o_rdy_a, 0);
        rdy_val = 1'b1;
      end
    join
    wait_drain_a();
    chk("lit_17_beats", 34'(a_beats - b0), 17 * 11);
    chk("lit_rdy_after_drain", o_rdy_a, 1);
    chk("lit_cnt_after_drain", o_pkt_cnt_a, 0);

    // Stray beat, abandoned frame, then a clean 4-word frame.
    b0 = a_beats; e0 = a_errs;
    send_beat(0, 32'hDEAD0001, 1'b0, 1'b0, 0);
    send_beat(0, 32'hDEAD0002, 1'b1, 1'b0, 0);
    send_beat(0, 32'hDEAD0003, 1'b0, 1'b0, 0);
    send_beat(0, 32'hDEAD0004, 1'b0, 1'b0, 0);
    send_frame(0, 4, 0, ETYPE_ARP);
    wait_drain_a();
    chk("lit_err_pulses", 34'(a_errs - e0), 2);
    chk("lit_err_beats", 34'(a_beats - b0), 4);

    // Randomized traffic with gaps, random ready, aborts and strays.
    rdy_mode = 2;
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 7) == 0) send_beat(0, $urandom, 1'b0, $urandom_range(0, 1) == 1, 0);
      if ($urandom_range(0, 5) == 0) begin
        send_beat(0, $urandom, 1'b1, 1'b0, 0);
        for (int k = 0; k < $urandom_range(0, 3); k++) send_beat(0, $urandom, 1'b0, 1'b0, 0);
      end
      send_frame(0, $urandom_range(1, 48), 2, ($urandom_range(0, 1) == 1) ? ETYPE_ARP : ETYPE_IPV4);
    end
    wait_drain_a();
    rdy_mode = 0; rdy_val = 1'b0;

    // Reset with one stored frame and five words of a partial frame.
    @(posedge clk); #1;
    send_frame(0, 3, 0, ETYPE_ARP);
    for (int k = 0; k < 5; k++) send_beat(0, $urandom, k == 0, 1'b0, 0);
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("lit_midrst_vld", o_vld_a, 0);
    chk("lit_midrst_cnt", o_pkt_cnt_a, 0);
    rst_n = 1'b1; rdy_val = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("lit_postrst_vld", o_vld_a, 0);
    b0 = a_beats;
    send_frame(0, 3, 0, ETYPE_ARP);
    wait_drain_a();
    chk("lit_postrst_beats", 34'(a_beats - b0), 3);

    // 16-word buffer: oversized frame dropped, next frame delivered intact.
    bb0 = b_beats; bd0 = b_drops; be0 = b_errs;
    send_frame(1, 20, 0, ETYPE_IPV4);
    repeat (10) begin @(posedge clk); #1; end
    chk("lit_b_drop", 34'(b_drops - bd0), 1);
    chk("lit_b_no_out", 34'(b_beats - bb0), 0);
    b_out.delete();
    send_frame(1, 3, 0, ETYPE_ARP);
    b_sent = sent_q;
    repeat (10) begin @(posedge clk); #1; end
    chk("lit_b_beats", 34'(b_beats - bb0), 3);
    chk("lit_b_noerr", 34'(b_errs - be0), 0);
    chk("lit_b_cnt", o_pkt_cnt_b, 0);
    for (int k = 0; k < 3; k++)
      chk("lit_b_data", (k < b_out.size()) ? b_out[k] : 32'hBAD0BAD0, b_sent[k]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
